// File: rtl/bram_row_streamer.sv
// Read-side sequencer for the softmax row BRAM: issues a contiguous read burst and streams
// the returned rows out on a valid/ready interface. Reads are credit-limited so the FIFO never overflows.
module bram_row_streamer #(
  parameter int unsigned DATA_W = 1028,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  output logic              o_cenb,
  output logic [ADDR_W-1:0] o_addrb,
  input  logic [DATA_W-1:0] i_doutb,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned Depth = RD_LAT + 2;
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned SumW  = CntW + 1;
  localparam int unsigned LenW  = ADDR_W + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LenW-1:0]     len_q, len_d;
  logic [LenW-1:0]     issued_q, issued_d;
  logic                cenb_q, cenb_d;
  logic                tag_q, tag_d;
  logic [ADDR_W-1:0]   addrb_q, addrb_d;
  logic                done_q, done_d;
  logic [RD_LAT-1:0]   en_sr_q, last_sr_q;
  logic [DATA_W-1:0]   fifo_data_q [Depth];
  logic [Depth-1:0]    fifo_last_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     cnt_q;
  logic [SumW-1:0]     inflight;
  logic                push, pop, issue, last_hs, credit_ok, final_issue;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign push    = en_sr_q[RD_LAT-1];
  assign pop     = o_valid & i_ready;
  assign last_hs = pop & fifo_last_q[rd_ptr_q];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_start && i_len != '0) state_d = StIssue;
      StIssue: if (issue && final_issue)   state_d = StDrain;
      StDrain: if (last_hs)                state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    // Reads already in the BRAM pipe count against FIFO space; a same-cycle pop frees one slot.
    inflight = SumW'(cenb_q);
    for (int i = 0; i < int'(RD_LAT); i++) inflight = inflight + SumW'(en_sr_q[i]);
    credit_ok   = (inflight + SumW'(cnt_q) - SumW'(pop)) < SumW'(Depth);
    issue       = (state_q == StIssue) && credit_ok;
    final_issue = (issued_q == len_q - LenW'(1));

    cenb_d   = issue;
    addrb_d  = issue ? addr_q : addrb_q;
    tag_d    = issue && final_issue;
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    if (state_q == StIdle && i_start) begin
      addr_d   = i_base;
      len_d    = i_len;
      issued_d = '0;
    end else if (issue) begin
      addr_d   = addr_q + ADDR_W'(1);
      issued_d = issued_q + LenW'(1);
    end
    done_d = ((state_q == StIdle) && i_start && (i_len == '0)) ||
             ((state_q == StDrain) && last_hs);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      cenb_q      <= 1'b0;
      tag_q       <= 1'b0;
      addrb_q     <= '0;
      done_q      <= 1'b0;
      en_sr_q     <= '0;
      last_sr_q   <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < int'(Depth); i++) fifo_data_q[i] <= '0;
    end else begin
      addr_q       <= addr_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      cenb_q       <= cenb_d;
      tag_q        <= tag_d;
      addrb_q      <= addrb_d;
      done_q       <= done_d;
      en_sr_q[0]   <= cenb_q;
      last_sr_q[0] <= tag_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        en_sr_q[i]   <= en_sr_q[i-1];
        last_sr_q[i] <= last_sr_q[i-1];
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= i_doutb;
        fifo_last_q[wr_ptr_q] <= last_sr_q[RD_LAT-1];
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  assign o_cenb  = cenb_q;
  assign o_addrb = addrb_q;
  assign o_valid = (cnt_q != '0);
  assign o_data  = fifo_data_q[rd_ptr_q];
  assign o_last  = o_valid & fifo_last_q[rd_ptr_q];
  assign o_busy  = (state_q != StIdle);
  assign o_done  = done_q;

  fifo_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
    !(push && !pop && (cnt_q == CntW'(Depth))));

endmodule

// File: tb/tb_bram_row_streamer.sv
// Scoreboard bench: drives RD_LAT=1 and RD_LAT=2 streamers with identical stimulus; a negedge
// monitor checks issued addresses, delivered rows, stall stability, latency and done pulses.
module tb_bram_row_streamer;
  localparam int unsigned DATA_W = 1028;
  localparam int unsigned ADDR_W = 8;

  logic              i_clk;
  logic              i_rstn;
  logic              i_start;
  logic [ADDR_W-1:0] i_base;
  logic [ADDR_W:0]   i_len;
  logic              i_ready;

  logic              cenb_w  [2];
  logic [ADDR_W-1:0] addrb_w [2];
  logic [DATA_W-1:0] doutb_w [2];
  logic              valid_w [2];
  logic [DATA_W-1:0] data_w  [2];
  logic              last_w  [2];
  logic              busy_w  [2];
  logic              done_w  [2];
  logic [DATA_W-1:0] l2_stage;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  bram_row_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1)) u_dut_l1 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_base(i_base), .i_len(i_len),
    .o_cenb(cenb_w[0]), .o_addrb(addrb_w[0]), .i_doutb(doutb_w[0]), .o_valid(valid_w[0]),
    .i_ready(i_ready), .o_data(data_w[0]), .o_last(last_w[0]), .o_busy(busy_w[0]),
    .o_done(done_w[0])
  );

  bram_row_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(2)) u_dut_l2 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_base(i_base), .i_len(i_len),
    .o_cenb(cenb_w[1]), .o_addrb(addrb_w[1]), .i_doutb(doutb_w[1]), .o_valid(valid_w[1]),
    .i_ready(i_ready), .o_data(data_w[1]), .o_last(last_w[1]), .o_busy(busy_w[1]),
    .o_done(done_w[1])
  );

  // Row k holds the 16-bit value k*0x11 replicated across the row.
  function automatic logic [DATA_W-1:0] row_val(input logic [ADDR_W-1:0] a);
    logic [15:0]       p;
    logic [DATA_W-1:0] r;
    p = 16'(a) * 16'h0011;
    for (int b = 0; b < int'(DATA_W); b++) r[b] = p[b % 16];
    return r;
  endfunction

  // BRAM models: one read register for RD_LAT=1, an extra output register for RD_LAT=2.
  always @(posedge i_clk) begin
    if (cenb_w[0]) doutb_w[0] <= row_val(addrb_w[0]);
    if (cenb_w[1]) l2_stage <= row_val(addrb_w[1]);
    doutb_w[1] <= l2_stage;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string nm, input int d, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut_lat%0d: got %0h, expected %0h (t=%0t)", nm, d + 1, act, req, $time);
    end
  endtask

  function automatic logic [6:0] outs(input int d);
    return {cenb_w[d], |addrb_w[d], valid_w[d], |data_w[d], last_w[d], busy_w[d], done_w[d]};
  endfunction

  logic [ADDR_W-1:0] exp_addr_q [$];
  bit                exp_last_q [$];
  int                rd_idx [2];
  int                is_idx [2];
  int                done_cnt [2];
  int                start_cyc [2];
  bit                hold_q [2], first_pend [2], last_hs_q [2], zl_q [2], nb_q [2];
  logic [DATA_W-1:0] prev_data [2];
  logic              prev_last [2];
  int                cyc = 0;
  int                rmode = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    bit                want_done, hs;
    logic [ADDR_W-1:0] a;
    for (int d = 0; d < 2; d++) begin
      if (!i_rstn) begin
        hold_q[d] = 0; first_pend[d] = 0; last_hs_q[d] = 0; zl_q[d] = 0; nb_q[d] = 0;
      end else begin
        want_done = last_hs_q[d] || zl_q[d];
        if (want_done || done_w[d])
          chk(done_w[d] == want_done && !busy_w[d], "done_pulse", d,
              64'({done_w[d], busy_w[d]}), 64'({want_done, 1'b0}));
        if (done_w[d]) done_cnt[d]++;
        if (hold_q[d])
          chk(valid_w[d] && data_w[d] == prev_data[d] && last_w[d] == prev_last[d],
              "stall_stable", d, data_w[d][63:0], prev_data[d][63:0]);
        if (nb_q[d]) chk(valid_w[d], "no_bubble", d, 64'(valid_w[d]), 64'(1));
        if (first_pend[d] && valid_w[d]) begin
          chk(cyc - start_cyc[d] - 1 == d + 3, "first_valid_latency", d,
              64'(cyc - start_cyc[d] - 1), 64'(d + 3));
          first_pend[d] = 0;
        end
        if (cenb_w[d]) begin
          if (is_idx[d] < exp_addr_q.size()) begin
            chk(addrb_w[d] == exp_addr_q[is_idx[d]], "issue_addr", d, 64'(addrb_w[d]),
                64'(exp_addr_q[is_idx[d]]));
            is_idx[d]++;
          end else chk(1'b0, "extra_issue", d, 64'(addrb_w[d]), 64'(0));
        end
        hs = valid_w[d] && i_ready;
        if (hs) begin
          if (rd_idx[d] < exp_addr_q.size()) begin
            a = exp_addr_q[rd_idx[d]];
            chk(data_w[d] == row_val(a) && last_w[d] == exp_last_q[rd_idx[d]], "row_data", d,
                {last_w[d], data_w[d][62:0]}, {exp_last_q[rd_idx[d]], row_val(a)[62:0]});
            rd_idx[d]++;
          end else chk(1'b0, "extra_row", d, data_w[d][63:0], 64'(0));
        end
        last_hs_q[d] = hs && last_w[d];
        zl_q[d]      = i_start && i_len == '0 && !busy_w[d];
        if (i_start && i_len != '0 && !busy_w[d]) begin
          first_pend[d] = 1;
          start_cyc[d]  = cyc;
        end
        hold_q[d]    = valid_w[d] && !i_ready;
        prev_data[d] = data_w[d];
        prev_last[d] = last_w[d];
        nb_q[d]      = hs && !last_w[d] && rmode == 0;
      end
    end
  end

  // Ready pattern generator: 0 = always ready, 1 = 1,0,0 repeating, 2 = same plus a 20-cycle stall.
  initial begin
    int rcnt;
    int pmode;
    rcnt = 0;
    pmode = 0;
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      if (rmode != pmode) begin
        rcnt  = 0;
        pmode = rmode;
      end
      rcnt++;
      case (rmode)
        1:       i_ready = (rcnt % 3 == 1);
        2:       i_ready = (rcnt >= 6 && rcnt < 26) ? 1'b0 : (rcnt % 3 == 1);
        default: i_ready = 1'b1;
      endcase
    end
  end

  task automatic push_burst(input int base, input int len);
    for (int k = 0; k < len; k++) begin
      exp_addr_q.push_back(ADDR_W'(base + k));
      exp_last_q.push_back(k == len - 1);
    end
  endtask

  task automatic pulse_start(input int base, input int len);
    @(posedge i_clk);
    #1;
    i_start = 1'b1;
    i_base  = ADDR_W'(base);
    i_len   = (ADDR_W + 1)'(len);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string nm);
    int n;
    n = 0;
    while ((done_cnt[0] < target || done_cnt[1] < target) && n < 3000) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    repeat (2) @(posedge i_clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(done_cnt[d] == target, {nm, "_done_count"}, d, 64'(done_cnt[d]), 64'(target));
      chk(rd_idx[d] == exp_addr_q.size() && is_idx[d] == exp_addr_q.size(),
          {nm, "_all_rows"}, d, 64'(rd_idx[d]), 64'(exp_addr_q.size()));
    end
  endtask

  initial begin
    int exp_done;
    int n;
    int base_i;
    bit seen;
    exp_done = 0;
    i_rstn  = 1'b0;
    i_start = 1'b0;
    i_base  = '0;
    i_len   = '0;
    repeat (3) @(posedge i_clk);
    #1;
    for (int d = 0; d < 2; d++) chk(outs(d) == '0, "reset_outputs", d, 64'(outs(d)), 64'(0));
    i_rstn = 1'b1;

    rmode = 0;
    push_burst(0, 4);    exp_done++; pulse_start(0, 4);    wait_done(exp_done, "basic");
    push_burst(250, 10); exp_done++; pulse_start(250, 10); wait_done(exp_done, "wrap");
    push_burst(0, 256);  exp_done++; pulse_start(0, 256);  wait_done(exp_done, "full_len");

    rmode = 1;
    push_burst(16, 8);   exp_done++; pulse_start(16, 8);   wait_done(exp_done, "toggle_ready");
    rmode = 2;
    push_burst(60, 8);   exp_done++; pulse_start(60, 8);   wait_done(exp_done, "long_stall");
    rmode = 0;

    exp_done++;
    seen = 0;
    pulse_start(77, 0);
    repeat (6) begin
      @(posedge i_clk);
      #1;
      for (int d = 0; d < 2; d++) seen |= cenb_w[d] | valid_w[d] | busy_w[d];
    end
    chk(!seen, "zero_len_quiet", 0, 64'(seen), 64'(0));
    wait_done(exp_done, "zero_len");

    push_burst(100, 5);
    exp_done++;
    pulse_start(100, 5);
    pulse_start(200, 7);
    wait_done(exp_done, "start_while_busy");

    push_burst(30, 8);
    base_i = rd_idx[0];
    pulse_start(30, 8);
    n = 0;
    while (rd_idx[0] - base_i < 3 && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk(rd_idx[0] - base_i == 3, "beats_before_reset", 0, 64'(rd_idx[0] - base_i), 64'(3));
    #2;
    i_rstn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(outs(d) == '0, "async_reset_outputs", d, 64'(outs(d)), 64'(0));
      rd_idx[d] = exp_addr_q.size();
      is_idx[d] = exp_addr_q.size();
    end
    repeat (3) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    for (int d = 0; d < 2; d++)
      chk(done_cnt[d] == exp_done, "no_done_after_reset", d, 64'(done_cnt[d]), 64'(exp_done));
    push_burst(40, 6);   exp_done++; pulse_start(40, 6);   wait_done(exp_done, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bram_row_streamer.md
Name: bram_row_streamer

Overview:
- Read-side sequencer for the 1028-bit x 256-row softmax BRAM.
- On a start command it issues a contiguous burst of BRAM reads and absorbs the fixed BRAM read latency.
- Presents rows to the downstream tree stage on a valid/ready stream with full backpressure support and no lost or duplicated rows.
- Reports completion to the control FSM.

Parameters:
- DATA_W, 1028, BRAM row width in bits.
- ADDR_W, 8, BRAM address width.
- RD_LAT, 1, BRAM read latency in cycles from enable/address to data. Legal values are 1 or 2.

Ports:
- i_clk  input  1  system clock
- i_rstn  input  1  asynchronous active-low reset
- i_start  input  1  one-cycle start pulse; ignored while o_busy=1
- i_base  input  ADDR_W  first row address, sampled on accepted start
- i_len  input  ADDR_W+1  number of rows, 0..256, sampled on accepted start
- o_cenb  output  1  BRAM read enable
- o_addrb  output  ADDR_W  BRAM read address
- i_doutb  input  DATA_W  BRAM read data, valid RD_LAT cycles after o_cenb
- o_valid  output  1  output row valid
- i_ready  input  1  downstream ready
- o_data  output  DATA_W  output row
- o_last  output  1  high with the final row of the burst
- o_busy  output  1  burst in progress
- o_done  output  1  one-cycle pulse when the final row handshakes or a zero-length burst completes

Behaviour:
- Reset (async assert, sync release): all outputs are 0, FSM is IDLE, FIFO is empty, all counters are 0. Reset mid-burst discards in-flight BRAM data; no o_done is produced.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE on i_start with i_len!=0. i_base and i_len are latched; o_busy=1 from the next cycle.
  - IDLE with i_start and i_len==0: o_done pulses the next cycle, o_busy stays 0.
  - ISSUE -> DRAIN after the cycle in which the i_len-th read is issued.
  - DRAIN -> IDLE on handshake (o_valid & i_ready) of the row with o_last=1. o_done pulses in the cycle after that handshake, together with o_busy falling.
- Read issue:
  - In ISSUE, o_cenb=1 in any cycle where credit is available: (outstanding reads + FIFO occupancy) < FIFO depth.
  - o_cenb and o_addrb are registered outputs.
  - o_addrb starts at i_base and increments by 1 per issued read, wrapping modulo 2^ADDR_W (base 250, len 10 reads 250..255, 0..3).
- Return path:
  - A RD_LAT-deep shift register of enable bits marks returning data.
  - Marked i_doutb is written into an output FIFO of depth RD_LAT+2, so a full-rate stream is sustained with no bubbles.
- Output:
  - o_valid = FIFO not empty. o_data is the FIFO head, and o_last is the head's last flag.
  - o_data and o_last hold stable while o_valid & !i_ready (stream rule).
  - Rows leave in address order.
  - o_valid never drops without a handshake.
- Throughput: with i_ready held at 1, one row per cycle.
- Latency: first o_valid appears RD_LAT+2 cycles after i_start (1 cycle latch, 1 cycle registered issue, RD_LAT cycles BRAM, then the FIFO write is visible).
- Backpressure: i_ready=0 for any duration stalls issue once credit is exhausted. The FIFO never overflows; an overflow is an assertion failure.
- Simultaneous events:
  - FIFO write and read in the same cycle leave occupancy unchanged.
  - Credit counts a read pop in the same cycle.
  - i_start coinciding with the final handshake is ignored, because o_busy is still 1.
- Counters: the issued count and the delivered count are ADDR_W+1 bits each. o_last is tagged on the read whose issue index equals len-1.

Test Plan:
- Basic burst, i_ready=1: base=0, len=4, with BRAM rows preloaded as row k = k*0x11 replicated. Required: 4 consecutive o_valid beats carrying rows 0..3, o_last on beat 4, o_done one cycle later, first o_valid exactly RD_LAT+2 cycles after i_start.
- Wrap and full length: base=250, len=10 -> o_addrb sequence 250..255, 0..3. Then base=0, len=256 -> 256 beats, o_last only on addr 255, no bubble.
- Backpressure: len=8, i_ready toggling 1,0,0,1,... plus a 20-cycle stall mid-burst. Required: no drop or duplicate, o_data stable during stalls, FIFO occupancy ≤ RD_LAT+2, o_cenb deasserts while credit is 0.
- Zero-length and start-while-busy: i_len=0 -> o_done pulse, no o_cenb, no o_valid. A second i_start during a len=5 burst is ignored; exactly 5 beats are delivered.
- Reset mid-burst: assert i_rstn=0 after 3 of 8 beats. Required: all outputs 0 immediately (async), no o_done. A fresh burst after release delivers correct data starting from its base.
- RD_LAT=2 variant: rerun the first and third scenarios. Required: identical data ordering, first o_valid at cycle 4 after i_start.
